tft_spi_rx_decoder: RTL and testbench

//  Display-side responder for the TFT SPI link: deserialises {RS,16-bit} words from SCK/MOSI/CS_n/RS and decodes them like the panel.
//  RS=0 words latch the register index. RS=1 words produce a register-write strobe, or a GRAM pixel write when the index is 0x22.

---
 rtl/tft_pkg.sv | 16 +
 rtl/tft_spi_rx_shifter.sv | 121 ++++++++++++
 rtl/tft_spi_rx_decoder.sv | 122 ++++++++++++
 tb/tb_tft_spi_rx_decoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared constants for the TFT SPI receive path: panel register indices and FSM state encoding.
package tft_pkg;

    localparam logic [7:0] IDX_RAM_ADDR1 = 8'h20;
    localparam logic [7:0] IDX_RAM_ADDR2 = 8'h21;
    localparam logic [7:0] IDX_GRAM_WR   = 8'h22;
    localparam logic [7:0] IDX_HWIN1     = 8'h36;
    localparam logic [7:0] IDX_HWIN2     = 8'h37;
    localparam logic [7:0] IDX_VWIN1     = 8'h38;
    localparam logic [7:0] IDX_VWIN2     = 8'h39;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_WORD  = 2'd2;

endpackage

// File: rtl/tft_spi_rx_shifter.sv
// Synchronises the SPI pins, detects SCK rises and assembles {RS,16-bit} words.
// TFT_RX_FRAMECHK_EN adds a pulse on o_frame_err when CS_n aborts a partial word.
module tft_spi_rx_shifter
    import tft_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sck,
    input  logic        i_mosi,
    input  logic        i_cs_n,
    input  logic        i_rs,
    output logic        o_word_valid,
    output logic        o_word_rs,
    output logic [15:0] o_word_data,
    output logic        o_frame_err,
    output logic [1:0]  o_state
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rs_sync;
    logic                   r_sck_d;
    logic [1:0]             r_state;
    logic [3:0]             r_cnt;
    logic [15:0]            r_shift;
    logic                   r_rs_cap;
    logic                   r_word_valid;
    logic                   r_word_rs;
    logic [15:0]            r_word_data;
    logic                   w_sck;
    logic                   w_mosi;
    logic                   w_cs_n;
    logic                   w_rs;
    logic                   w_sck_rise;

    // CS_n synchroniser resets to the deselected level so reset never looks like a frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_rs_sync   <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_rs_sync   <= {r_rs_sync[SYNC_STAGES-2:0], i_rs};
            r_sck_d     <= w_sck;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_rs       = r_rs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_shift      <= 16'd0;
            r_rs_cap     <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_rs    <= 1'b0;
            r_word_data  <= 16'd0;
        end else begin
            r_word_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    if (!w_cs_n) r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_cs_n) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (w_sck_rise) begin
                        r_shift <= {r_shift[14:0], w_mosi};
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_rs_cap <= w_rs;
                            r_state  <= ST_WORD;
                        end
                    end
                end
                ST_WORD: begin
                    r_word_valid <= 1'b1;
                    r_word_rs    <= r_rs_cap;
                    r_word_data  <= r_shift;
                    r_cnt        <= 4'd0;
                    r_state      <= w_cs_n ? ST_IDLE : ST_SHIFT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TFT_RX_FRAMECHK_EN
    logic r_frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_frame_err <= 1'b0;
        else       r_frame_err <= (r_state == ST_SHIFT) && w_cs_n && (r_cnt != 4'd0);
    end

    assign o_frame_err = r_frame_err;
`else
    assign o_frame_err = 1'b0;
`endif

    assign o_word_valid = r_word_valid;
    assign o_word_rs    = r_word_rs;
    assign o_word_data  = r_word_data;
    assign o_state      = r_state;

endmodule

// File: rtl/tft_spi_rx_decoder.sv
// Panel-side decoder: turns received SPI words into register writes and windowed GRAM pixel writes.
// Optional macro TFT_RX_FRAMECHK_EN enables frame_err (generated in the shifter).
module tft_spi_rx_decoder
    import tft_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] H_END_RST   = 8'hAF,
    parameter logic [7:0] V_END_RST   = 8'hDB
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    input  logic        spi_rs,
    output logic        word_valid,
    output logic        word_rs,
    output logic [15:0] word_data,
    output logic        reg_wr,
    output logic [7:0]  reg_idx,
    output logic [15:0] reg_data,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        frame_err,
    output logic [1:0]  dbg_state
);

    logic        w_word_valid;
    logic        w_word_rs;
    logic [15:0] w_word_data;
    logic        r_reg_wr;
    logic [7:0]  r_idx;
    logic [15:0] r_reg_data;
    logic        r_pix_valid;
    logic [15:0] r_pix_data;
    logic [7:0]  r_pix_x;
    logic [7:0]  r_pix_y;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_hsa;
    logic [7:0]  r_hea;
    logic [7:0]  r_vsa;
    logic [7:0]  r_vea;

    tft_spi_rx_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_sck        (spi_sck),
        .i_mosi       (spi_mosi),
        .i_cs_n       (spi_cs_n),
        .i_rs         (spi_rs),
        .o_word_valid (w_word_valid),
        .o_word_rs    (w_word_rs),
        .o_word_data  (w_word_data),
        .o_frame_err  (frame_err),
        .o_state      (dbg_state)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg_wr    <= 1'b0;
            r_idx       <= 8'd0;
            r_reg_data  <= 16'd0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= 16'd0;
            r_pix_x     <= 8'd0;
            r_pix_y     <= 8'd0;
            r_x         <= 8'd0;
            r_y         <= 8'd0;
            r_hsa       <= 8'd0;
            r_hea       <= H_END_RST;
            r_vsa       <= 8'd0;
            r_vea       <= V_END_RST;
        end else begin
            r_reg_wr    <= 1'b0;
            r_pix_valid <= 1'b0;
            if (w_word_valid) begin
                if (!w_word_rs) begin
                    r_idx <= w_word_data[7:0];
                end else if (r_idx == IDX_GRAM_WR) begin
                    r_pix_valid <= 1'b1;
                    r_pix_data  <= w_word_data;
                    r_pix_x     <= r_x;
                    r_pix_y     <= r_y;
                    // Equality-only window: an address beyond the end runs on and wraps at 8 bits.
                    if (r_x != r_hea) begin
                        r_x <= r_x + 8'd1;
                    end else begin
                        r_x <= r_hsa;
                        r_y <= (r_y == r_vea) ? r_vsa : r_y + 8'd1;
                    end
                end else begin
                    r_reg_wr   <= 1'b1;
                    r_reg_data <= w_word_data;
                    case (r_idx)
                        IDX_RAM_ADDR1: r_x   <= w_word_data[7:0];
                        IDX_RAM_ADDR2: r_y   <= w_word_data[7:0];
                        IDX_HWIN1:     r_hea <= w_word_data[7:0];
                        IDX_HWIN2:     r_hsa <= w_word_data[7:0];
                        IDX_VWIN1:     r_vea <= w_word_data[7:0];
                        IDX_VWIN2:     r_vsa <= w_word_data[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign word_valid = w_word_valid;
    assign word_rs    = w_word_rs;
    assign word_data  = w_word_data;
    assign reg_wr     = r_reg_wr;
    assign reg_idx    = r_idx;
    assign reg_data   = r_reg_data;
    assign pix_valid  = r_pix_valid;
    assign pix_data   = r_pix_data;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;

endmodule

// File: tb/tb_tft_spi_rx_decoder.sv
// Bench for tft_spi_rx_decoder: directed vector table, multi-cycle abort/reset sequences, random words vs a panel model.
module tb_tft_spi_rx_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_rs = 1'b0;
    logic        word_valid;
    logic        word_rs;
    logic [15:0] word_data;
    logic        reg_wr;
    logic [7:0]  reg_idx;
    logic [15:0] reg_data;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic        frame_err;
    logic [1:0]  dbg_state;

    tft_spi_rx_decoder dut (
        .CLK        (CLK),
        .RST        (RST),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_rs     (spi_rs),
        .word_valid (word_valid),
        .word_rs    (word_rs),
        .word_data  (word_data),
        .reg_wr     (reg_wr),
        .reg_idx    (reg_idx),
        .reg_data   (reg_data),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_err  (frame_err),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int fe_exp;

    logic [16:0] exp_word_q[$];
    logic [23:0] exp_reg_q[$];
    logic [31:0] exp_pix_q[$];

    // Panel reference model: register file and GRAM address pointer
    int m_idx, m_x, m_y, m_hsa, m_hea, m_vsa, m_vea;

    typedef struct {
        logic        rs;
        logic [15:0] data;
        int          kind;   // 0 none, 1 register write, 2 pixel
        logic [7:0]  idx;
        logic [7:0]  x;
        logic [7:0]  y;
        bit          eof;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_x = 0; m_y = 0;
        m_hsa = 0; m_hea = 'hAF; m_vsa = 0; m_vea = 'hDB;
    endtask

    task automatic model_word(input logic rs, input logic [15:0] data, input bit push);
        int d;
        d = data[7:0];
        if (push) exp_word_q.push_back({rs, data});
        if (!rs) begin
            m_idx = d;
        end else if (m_idx == 'h22) begin
            if (push) exp_pix_q.push_back({m_x[7:0], m_y[7:0], data});
            if (m_x == m_hea) begin
                m_x = m_hsa;
                m_y = (m_y == m_vea) ? m_vsa : (m_y + 1) % 256;
            end else begin
                m_x = (m_x + 1) % 256;
            end
        end else begin
            if (push) exp_reg_q.push_back({m_idx[7:0], data});
            case (m_idx)
                'h20: m_x = d;
                'h21: m_y = d;
                'h36: m_hea = d;
                'h37: m_hsa = d;
                'h38: m_vea = d;
                'h39: m_vsa = d;
                default: ;
            endcase
        end
    endtask

    // Driver tasks
    task automatic frame_begin();
        spi_cs_n = 1'b0;
        #60;
    endtask

    task automatic frame_end();
        #40;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic send_bits(input logic rs, input logic [15:0] data, input int nbits);
        for (int i = 15; i >= 16 - nbits; i--) begin
            spi_rs   = rs;
            spi_mosi = data[i];
            #40 spi_sck = 1'b1;
            #40 spi_sck = 1'b0;
        end
    endtask

    task automatic send_word(input logic rs, input logic [15:0] data);
        model_word(rs, data, 1'b1);
        send_bits(rs, data, 16);
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = 0;
        for (int i = 0; i < 400; i++) begin
            left = exp_word_q.size() + exp_reg_q.size() + exp_pix_q.size();
            if (left == 0) break;
            @(posedge CLK);
        end
        left = exp_word_q.size() + exp_reg_q.size() + exp_pix_q.size();
        chk(name, left, 0);
        exp_word_q.delete(); exp_reg_q.delete(); exp_pix_q.delete();
        repeat (5) @(posedge CLK);
    endtask

    task automatic add(input logic rs, input logic [15:0] data, input int kind,
                       input logic [7:0] idx, input logic [7:0] x, input logic [7:0] y, input bit eof);
        vec_t v;
        v.rs = rs; v.data = data; v.kind = kind; v.idx = idx; v.x = x; v.y = y; v.eof = eof;
        vecs.push_back(v);
    endtask

    // Scoreboard: every strobe must match the head of its expected queue
    always @(negedge CLK) begin
        if (word_valid) begin
            if (exp_word_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL word_unexpected: got %h expected none", {word_rs, word_data});
            end else chk("word", {word_rs, word_data}, exp_word_q.pop_front());
        end
        if (reg_wr) begin
            if (exp_reg_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL reg_wr_unexpected: got %h expected none", {reg_idx, reg_data});
            end else chk("reg_wr", {reg_idx, reg_data}, exp_reg_q.pop_front());
        end
        if (pix_valid) begin
            if (exp_pix_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL pix_unexpected: got %h expected none", {pix_x, pix_y, pix_data});
            end else chk("pixel", {pix_x, pix_y, pix_data}, exp_pix_q.pop_front());
        end
        if (frame_err) fe_cnt++;
    end

    initial begin
`ifdef TFT_RX_FRAMECHK_EN
        fe_exp = 1;
`else
        fe_exp = 0;
`endif
        model_reset();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_word", {word_valid, word_rs, word_data}, 0);
        chk("rst_reg", {reg_wr, reg_idx, reg_data}, 0);
        chk("rst_pix", {pix_valid, pix_x, pix_y, pix_data}, 0);
        chk("rst_misc", {frame_err, dbg_state}, 0);
        @(negedge CLK) RST = 1'b0;
        repeat (3) @(posedge CLK);

        // Directed vectors with hand-computed expectations
        add(0, 16'h0010, 0, 8'h00, 0, 0, 0);
        add(1, 16'h0000, 1, 8'h10, 0, 0, 1);
        add(0, 16'h0020, 0, 8'h00, 0, 0, 0);
        add(1, 16'h00AF, 1, 8'h20, 0, 0, 0);
        add(0, 16'h0021, 0, 8'h00, 0, 0, 0);
        add(1, 16'h0000, 1, 8'h21, 0, 0, 0);
        add(0, 16'h0022, 0, 8'h00, 0, 0, 0);
        add(1, 16'hF800, 2, 8'h00, 8'd175, 8'd0, 0);
        add(1, 16'h07E0, 2, 8'h00, 8'd0, 8'd1, 1);
        add(0, 16'h0020, 0, 8'h00, 0, 0, 1);
        add(1, 16'h00AF, 1, 8'h20, 0, 0, 1);
        add(0, 16'h0021, 0, 8'h00, 0, 0, 0);
        add(1, 16'h00DB, 1, 8'h21, 0, 0, 0);
        add(0, 16'h0022, 0, 8'h00, 0, 0, 0);
        add(1, 16'h1234, 2, 8'h00, 8'd175, 8'd219, 0);
        add(1, 16'h5678, 2, 8'h00, 8'd0, 8'd0, 1);
        add(0, 16'h0036, 0, 8'h00, 0, 0, 0);
        add(1, 16'h000A, 1, 8'h36, 0, 0, 0);
        add(0, 16'h0037, 0, 8'h00, 0, 0, 0);
        add(1, 16'h0005, 1, 8'h37, 0, 0, 0);
        add(0, 16'h0020, 0, 8'h00, 0, 0, 0);
        add(1, 16'h000A, 1, 8'h20, 0, 0, 0);
        add(0, 16'h0021, 0, 8'h00, 0, 0, 0);
        add(1, 16'h0000, 1, 8'h21, 0, 0, 0);
        add(0, 16'h0022, 0, 8'h00, 0, 0, 0);
        add(1, 16'hAAAA, 2, 8'h00, 8'd10, 8'd0, 0);
        add(1, 16'hBBBB, 2, 8'h00, 8'd5, 8'd1, 0);
        add(1, 16'hCCCC, 2, 8'h00, 8'd6, 8'd1, 0);
        add(1, 16'hDDDD, 2, 8'h00, 8'd7, 8'd1, 1);

        begin
            bit in_frame;
            in_frame = 0;
            foreach (vecs[i]) begin
                if (!in_frame) begin frame_begin(); in_frame = 1; end
                model_word(vecs[i].rs, vecs[i].data, 1'b0);
                exp_word_q.push_back({vecs[i].rs, vecs[i].data});
                if (vecs[i].kind == 1) exp_reg_q.push_back({vecs[i].idx, vecs[i].data});
                if (vecs[i].kind == 2) exp_pix_q.push_back({vecs[i].x, vecs[i].y, vecs[i].data});
                send_bits(vecs[i].rs, vecs[i].data, 16);
                if (vecs[i].eof) begin frame_end(); in_frame = 0; end
            end
        end
        wait_drain("table_drain");
        chk("table_reg_idx", reg_idx, 8'h22);

        // Aborted partial word, then a clean word
        fe_cnt = 0;
        frame_begin();
        send_bits(1'b1, 16'hFFFF, 9);
        frame_end();
        repeat (10) @(posedge CLK);
        chk("abort_frame_err", fe_cnt, fe_exp);
        frame_begin();
        send_word(1'b0, 16'h0021);
        send_word(1'b1, 16'h0033);
        frame_end();
        wait_drain("abort_drain");
        chk("abort_reg_idx", reg_idx, 8'h21);

        // Reset in the middle of a pixel word
        frame_begin();
        send_word(1'b0, 16'h0022);
        wait_drain("prerst_drain");
        send_bits(1'b1, 16'h9999, 8);
        RST = 1'b1;
        #20;
        chk("midrst_reg", {reg_wr, reg_idx, reg_data}, 0);
        chk("midrst_pix", {pix_valid, pix_x, pix_y, pix_data}, 0);
        chk("midrst_word", {word_valid, word_rs, word_data, dbg_state}, 0);
        spi_cs_n = 1'b1;
        #100;
        @(negedge CLK) RST = 1'b0;
        model_reset();
        repeat (5) @(posedge CLK);
        frame_begin();
        send_word(1'b0, 16'h0022);
        send_word(1'b1, 16'h4321);
        frame_end();
        wait_drain("postrst_drain");
        chk("postrst_reg_idx", reg_idx, 8'h22);

        // Random frames against the model
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(1, 4);
            frame_begin();
            for (int w = 0; w < nw; w++) begin
                logic [15:0] d;
                d = 16'($urandom);
                if ($urandom_range(0, 9) < 3) begin
                    case ($urandom_range(0, 7))
                        0: d[7:0] = 8'h20;
                        1: d[7:0] = 8'h21;
                        2, 3: d[7:0] = 8'h22;
                        4: d[7:0] = 8'h36;
                        5: d[7:0] = 8'h37;
                        6: d[7:0] = 8'h38;
                        default: d[7:0] = 8'h39;
                    endcase
                    send_word(1'b0, d);
                end else begin
                    if (m_idx != 'h22) d[7:0] = 8'($urandom_range(0, 15));
                    send_word(1'b1, d);
                end
            end
            frame_end();
        end
        wait_drain("random_drain");
        chk("random_reg_idx", reg_idx, m_idx[7:0]);
        chk("final_frame_err", fe_cnt, fe_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
